// File: rtl/chart_sequencer.sv
// chart_sequencer: walks a chart ROM from address 0 and offers one note event
// per entry after that entry's tick delay. Handles rests, end markers, pause,
// abort and a ready/valid handshake on the note output.
module chart_sequencer #(
    parameter logic [7:0] END_ADDR = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        tick,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        note_valid,
    input  logic        note_ready,
    output logic [3:0]  note_lanes,
    output logic [7:0]  note_index,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  addr_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [7:0]  dly, dly_nx;
    logic [3:0]  mask, mask_nx;
    logic        ent_end, ent_end_nx;
    logic        done_nx;
    logic        adv;
    logic        unused_bits;

    // Reserved entry bits and the latched end flag carry no behaviour.
    assign unused_bits = ^{rom_data[14:12], ent_end};

    // State and datapath registers; rst beats stop and start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rom_addr <= 8'd0;
            cnt      <= 8'd0;
            dly      <= 8'd0;
            mask     <= 4'd0;
            ent_end  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            rom_addr <= addr_nx;
            cnt      <= cnt_nx;
            dly      <= dly_nx;
            mask     <= mask_nx;
            ent_end  <= ent_end_nx;
            done     <= done_nx;
        end
    end

    // Next-state logic: sequencing, tick counting, advance and abort.
    always_comb begin
        state_nx   = state;
        addr_nx    = rom_addr;
        cnt_nx     = cnt;
        dly_nx     = dly;
        mask_nx    = mask;
        ent_end_nx = ent_end;
        adv        = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = S_FETCH;
                    addr_nx  = 8'd0;
                    cnt_nx   = 8'd0;
                end
            end
            S_FETCH: begin
                dly_nx     = rom_data[11:4];
                mask_nx    = rom_data[3:0];
                ent_end_nx = rom_data[15];
                if (rom_data[15])
                    state_nx = S_DONE;
                else if (rom_data[11:4] != 8'd0)
                    state_nx = S_WAIT;
                else if (rom_data[3:0] != 4'd0)
                    state_nx = S_EMIT;
                else
                    adv = 1'b1;   // zero-delay rest
            end
            S_WAIT: begin
                // Ticks under pause are dropped, not deferred.
                if (tick && !pause) begin
                    if (cnt + 8'd1 == dly) begin
                        if (mask != 4'd0)
                            state_nx = S_EMIT;
                        else
                            adv = 1'b1;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
            end
            S_EMIT: begin
                if (note_ready)
                    adv = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase

        // Stop at the last address instead of wrapping to 0.
        if (adv) begin
            if (rom_addr == END_ADDR) begin
                state_nx = S_DONE;
            end else begin
                state_nx = S_FETCH;
                addr_nx  = rom_addr + 8'd1;
                cnt_nx   = 8'd0;
            end
        end

        if (stop) begin
            state_nx   = S_IDLE;
            addr_nx    = 8'd0;
            cnt_nx     = 8'd0;
            dly_nx     = 8'd0;
            mask_nx    = 4'd0;
            ent_end_nx = 1'b0;
        end

        done_nx = (state_nx == S_DONE) && (state != S_DONE);
    end

    assign note_valid = (state == S_EMIT);
    assign note_lanes = note_valid ? mask : 4'd0;
    assign note_index = note_valid ? rom_addr : 8'd0;
    assign busy       = (state == S_FETCH) || (state == S_WAIT) || (state == S_EMIT);

endmodule
